// File: rtl/instruction_memory_ctrl.sv
// instruction_memory_ctrl: byte-loadable instruction memory with a registered 32-bit fetch port.
//
// Ports:
//   clk, reset (async, active-low)
//   load_start/load_valid/load_byte/load_last -> byte-serial program loader
//   load_ready, load_done, load_err, busy      <- loader status
//   fetch_req/pc                               -> fetch request, pc sampled on the same edge
//   fetch_valid, instruction_code, fetch_fault <- fetch response, one cycle later
//
// Build option: define IMEM_BOOT_PROG_EN to preload words 0/1 at reset and start in RUN.
module instruction_memory_ctrl #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 32,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_err,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    output logic              fetch_valid,
    output logic [31:0]       instruction_code,
    output logic              fetch_fault,
    output logic              busy
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    // One extra bit so the pointer can park at DEPTH_WORDS*4 without wrapping.
    localparam int unsigned PW = AW + 3;
    localparam logic [PW-1:0] PTR_END = PW'(DEPTH_WORDS * 4);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
`ifdef IMEM_BOOT_PROG_EN
    localparam logic [1:0]  ST_RESET = ST_RUN;
    localparam logic [31:0] BOOT_W0  = 32'h0094_0333;
    localparam logic [31:0] BOOT_W1  = 32'h8001_0033;
`else
    localparam logic [1:0]  ST_RESET = ST_IDLE;
`endif

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [1:0]    state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          fv_q, fv_d;
    logic          ff_q, ff_d;
    logic [31:0]   code_q, code_d;

    logic          in_load, xfer, ptr_full, wr_en, pc_oor, fault;
    logic [AW-1:0] wr_word;
    logic [1:0]    wr_lane;

    assign in_load  = state_q == ST_LOAD;
    // A restart in the same cycle wins over any byte offered alongside it.
    assign xfer     = in_load & load_valid & ~load_start;
    assign ptr_full = ptr_q >= PTR_END;
    assign wr_en    = xfer & ~ptr_full;
    assign wr_word  = ptr_q[AW+1:2];
    assign wr_lane  = ptr_q[1:0];
    assign pc_oor   = (pc >> (AW + 2)) != '0;
    assign fault    = (state_q != ST_RUN) | (pc[1:0] != 2'b00) | pc_oor;

    always_comb begin
        state_d = load_start ? ST_LOAD : (xfer & load_last) ? ST_RUN : state_q;
        ptr_d   = load_start ? '0 : wr_en ? ptr_q + 1'b1 : ptr_q;
        err_d   = load_start ? 1'b0 : err_q | (xfer & ptr_full);
        done_d  = xfer & load_last;
        fv_d    = fetch_req;
        ff_d    = fetch_req & fault;
        // Read sees the array before this edge's byte write lands.
        code_d  = ~fetch_req ? code_q : fault ? NOP_WORD : mem_q[pc[AW+1:2]];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RESET;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            fv_q    <= 1'b0;
            ff_q    <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            done_q  <= done_d;
            fv_q    <= fv_d;
            ff_q    <= ff_d;
            code_q  <= code_d;
        end
    end

`ifdef IMEM_BOOT_PROG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q[0] <= BOOT_W0;
            mem_q[1] <= BOOT_W1;
        end else if (wr_en) begin
            mem_q[wr_word][{wr_lane, 3'b000} +: 8] <= load_byte;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_word][{wr_lane, 3'b000} +: 8] <= load_byte;
        end
    end
`endif

    assign load_ready       = in_load;
    assign busy             = in_load;
    assign load_done        = done_q;
    assign load_err         = err_q;
    assign fetch_valid      = fv_q;
    assign fetch_fault      = ff_q;
    assign instruction_code = code_q;
endmodule

// File: tb/tb_instruction_memory_ctrl.sv
// tb_instruction_memory_ctrl: randomized self-checking bench against a byte-array reference model.
module tb_instruction_memory_ctrl;
    localparam int DW = 4;
    localparam int NB = DW * 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0, fetch_req = 1'b0;
    logic [7:0]  load_byte = 8'h00;
    logic [31:0] pc = 32'h0;
    logic        load_ready, load_done, load_err, fetch_valid, fetch_fault, busy;
    logic [31:0] instruction_code;

    // Reference model: byte image, per-byte written flags, controller mode (0 idle, 1 load, 2 run).
    logic [7:0]  mb [NB];
    bit          mk [NB];
    int          ms, mp;
    bit          me, e_fv, e_ff, e_done, e_known;
    logic [31:0] e_code;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    instruction_memory_ctrl #(.DEPTH_WORDS(DW), .ADDR_W(32), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset),
        .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last),
        .load_ready(load_ready), .load_done(load_done), .load_err(load_err),
        .fetch_req(fetch_req), .pc(pc),
        .fetch_valid(fetch_valid), .instruction_code(instruction_code), .fetch_fault(fetch_fault),
        .busy(busy)
    );

    task automatic model_reset;
        for (int i = 0; i < NB; i++) mk[i] = 1'b0;
        ms = 0; mp = 0; me = 1'b0;
        e_fv = 1'b0; e_ff = 1'b0; e_done = 1'b0; e_code = 32'h0; e_known = 1'b1;
`ifdef IMEM_BOOT_PROG_EN
        ms = 2;
        {mb[3], mb[2], mb[1], mb[0]} = 32'h0094_0333;
        {mb[7], mb[6], mb[5], mb[4]} = 32'h8001_0033;
        for (int i = 0; i < 8; i++) mk[i] = 1'b1;
`endif
    endtask

    task automatic idle_inputs;
        load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; fetch_req = 1'b0;
        load_byte = 8'h00; pc = 32'h0;
    endtask

    // Advance one clock and update the model from the inputs presented for that edge.
    task automatic tick;
        int a;
        e_fv = fetch_req;
        e_done = 1'b0;
        e_ff = 1'b0;
        if (fetch_req) begin
            e_ff = (ms != 2) || (pc % 4 != 0) || (pc >= 32'(NB));
            if (e_ff) begin
                e_code = NOP;
                e_known = 1'b1;
            end else begin
                a = int'(pc);
                e_code = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
                e_known = mk[a] && mk[a+1] && mk[a+2] && mk[a+3];
            end
        end
        if (load_start) begin
            ms = 1; mp = 0; me = 1'b0;
        end else if (ms == 1 && load_valid) begin
            if (mp < NB) begin
                mb[mp] = load_byte; mk[mp] = 1'b1; mp++;
            end else begin
                me = 1'b1;
            end
            if (load_last) begin
                ms = 2; e_done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        int r;
        r = $urandom_range(0, 7);
        if (r < 6) return 32'($urandom_range(0, DW - 1) * 4);
        if (r == 6) return 32'($urandom_range(0, DW - 1) * 4 + $urandom_range(1, 3));
        return 32'(NB + 4 * $urandom_range(0, 3));
    endfunction

    task automatic test_reset;
        idle_inputs();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({load_ready, load_done, load_err, fetch_valid, fetch_fault, busy} !== 6'b0 || instruction_code !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: got ready=%b done=%b err=%b fv=%b ff=%b busy=%b code=%h, want all 0",
                     load_ready, load_done, load_err, fetch_valid, fetch_fault, busy, instruction_code);
        end
        reset = 1'b1;
        fetch_req = 1'b1;
`ifdef IMEM_BOOT_PROG_EN
        pc = 32'd4;
`else
        pc = 32'd0;
`endif
        tick();
        fetch_req = 1'b0;
        tests++;
        if (fetch_valid !== 1'b1 || fetch_fault !== e_ff || instruction_code !== e_code) begin
            fails++;
            $display("FAIL first_fetch: got fv=%b ff=%b code=%h, want fv=1 ff=%b code=%h",
                     fetch_valid, fetch_fault, instruction_code, e_ff, e_code);
        end
        tests++;
`ifdef IMEM_BOOT_PROG_EN
        if (fetch_fault !== 1'b0 || instruction_code !== 32'h8001_0033) begin
`else
        if (fetch_fault !== 1'b1 || instruction_code !== NOP) begin
`endif
            fails++;
            $display("FAIL first_fetch_const: got ff=%b code=%h", fetch_fault, instruction_code);
        end
    endtask

    task automatic test_load;
        logic [7:0] prog [8];
        int dones;
        prog = '{8'h33, 8'h03, 8'h94, 8'h00, 8'h33, 8'h00, 8'h01, 8'h80};
        dones = 0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        tests++;
        if (load_ready !== 1'b1 || busy !== 1'b1 || load_err !== 1'b0) begin
            fails++;
            $display("FAIL load_enter: got ready=%b busy=%b err=%b, want 1 1 0", load_ready, busy, load_err);
        end
        for (int i = 0; i < 8; i++) begin
            load_valid = 1'b1; load_byte = prog[i]; load_last = (i == 7);
            tick();
            if (load_done === 1'b1) dones++;
        end
        load_valid = 1'b0; load_last = 1'b0;
        tests++;
        if (load_ready !== 1'b0 || busy !== 1'b0 || load_done !== 1'b1) begin
            fails++;
            $display("FAIL load_exit: got ready=%b busy=%b done=%b, want 0 0 1", load_ready, busy, load_done);
        end
        tick();
        if (load_done === 1'b1) dones++;
        tests++;
        if (dones != 1) begin
            fails++;
            $display("FAIL load_done_count: got %0d pulses, want 1", dones);
        end
        fetch_req = 1'b1; pc = 32'd0;
        tick();
        tests++;
        if (fetch_valid !== 1'b1 || fetch_fault !== 1'b0 || instruction_code !== 32'h0094_0333) begin
            fails++;
            $display("FAIL fetch_pc0: got fv=%b ff=%b code=%h, want 1 0 00940333", fetch_valid, fetch_fault, instruction_code);
        end
        pc = 32'd4;
        tick();
        fetch_req = 1'b0;
        tests++;
        if (fetch_valid !== 1'b1 || fetch_fault !== 1'b0 || instruction_code !== 32'h8001_0033) begin
            fails++;
            $display("FAIL fetch_pc4: got fv=%b ff=%b code=%h, want 1 0 80010033", fetch_valid, fetch_fault, instruction_code);
        end
        tick();
        tests++;
        if (fetch_valid !== 1'b0 || instruction_code !== 32'h8001_0033) begin
            fails++;
            $display("FAIL fetch_hold: got fv=%b code=%h, want 0 80010033", fetch_valid, instruction_code);
        end
    endtask

    task automatic test_fault;
        logic [31:0] pcs [3];
        pcs = '{32'd2, 32'(NB), 32'hFFFF_FFFC};
        for (int i = 0; i < 3; i++) begin
            fetch_req = 1'b1; pc = pcs[i];
            tick();
            tests++;
            if (fetch_valid !== 1'b1 || fetch_fault !== 1'b1 || instruction_code !== NOP) begin
                fails++;
                $display("FAIL fault_pc_%h: got fv=%b ff=%b code=%h, want 1 1 %h", pcs[i], fetch_valid, fetch_fault, instruction_code, NOP);
            end
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_overflow;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < NB + 2; i++) begin
            load_valid = 1'b1; load_byte = 8'($urandom); load_last = (i == NB + 1);
            tick();
            if (i == NB - 1) begin
                tests++;
                if (load_err !== 1'b0) begin
                    fails++;
                    $display("FAIL ovf_early: got err=%b, want 0", load_err);
                end
            end
            if (i == NB) begin
                tests++;
                if (load_err !== 1'b1) begin
                    fails++;
                    $display("FAIL ovf_set: got err=%b, want 1", load_err);
                end
            end
        end
        load_valid = 1'b0; load_last = 1'b0;
        for (int w = 0; w < DW; w++) begin
            fetch_req = 1'b1; pc = 32'(w * 4);
            tick();
            tests++;
            if (fetch_fault !== 1'b0 || instruction_code !== e_code || load_err !== 1'b1) begin
                fails++;
                $display("FAIL ovf_word%0d: got ff=%b code=%h err=%b, want 0 %h 1", w, fetch_fault, instruction_code, load_err, e_code);
            end
        end
        fetch_req = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        tests++;
        if (load_err !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: got err=%b, want 0", load_err);
        end
        load_valid = 1'b1; load_byte = 8'h5A; load_last = 1'b1;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic test_collide;
        fetch_req = 1'b1; pc = 32'd0; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        tests++;
        if (fetch_fault !== 1'b0 || instruction_code !== e_code || busy !== 1'b1) begin
            fails++;
            $display("FAIL collide_start: got ff=%b code=%h busy=%b, want 0 %h 1", fetch_fault, instruction_code, busy, e_code);
        end
        load_valid = 1'b1; load_byte = 8'hAA; load_last = 1'b0;
        tick();
        tests++;
        if (fetch_fault !== 1'b1 || instruction_code !== NOP) begin
            fails++;
            $display("FAIL collide_inload: got ff=%b code=%h, want 1 %h", fetch_fault, instruction_code, NOP);
        end
        load_byte = 8'hBB; load_last = 1'b1;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        tests++;
        if (fetch_fault !== 1'b1 || load_done !== 1'b1) begin
            fails++;
            $display("FAIL collide_last: got ff=%b done=%b, want 1 1", fetch_fault, load_done);
        end
        tick();
        fetch_req = 1'b0;
        tests++;
        if (fetch_fault !== 1'b0 || instruction_code !== e_code || instruction_code[15:0] !== 16'hBBAA) begin
            fails++;
            $display("FAIL collide_after: got ff=%b code=%h, want 0 %h", fetch_fault, instruction_code, e_code);
        end
    endtask

    task automatic test_random;
        int len, i;
        for (int it = 0; it < 4; it++) begin
            len = $urandom_range(1, NB + 3);
            load_start = 1'b1; fetch_req = 1'($urandom); pc = rand_pc();
            tick();
            load_start = 1'b0;
            i = 0;
            for (int cyc = 0; cyc < 200 && i < len + 20; cyc++) begin
                load_valid = (i < len) && ($urandom_range(0, 3) != 0);
                load_byte = 8'($urandom);
                load_last = load_valid && (i == len - 1);
                fetch_req = 1'($urandom);
                pc = rand_pc();
                load_start = (i < len) && ($urandom_range(0, 40) == 0);
                if (load_start) i = 0;
                else if (load_valid || i >= len) i++;
                tick();
                tests++;
                if (fetch_valid !== e_fv || fetch_fault !== e_ff || (e_known && instruction_code !== e_code) ||
                    load_done !== e_done || load_err !== me || load_ready !== (ms == 1) || busy !== (ms == 1)) begin
                    fails++;
                    $display("FAIL random_it%0d_cyc%0d: got fv=%b ff=%b code=%h done=%b err=%b ready=%b busy=%b, want fv=%b ff=%b code=%h done=%b err=%b ready/busy=%b",
                             it, cyc, fetch_valid, fetch_fault, instruction_code, load_done, load_err, load_ready, busy,
                             e_fv, e_ff, e_code, e_done, me, ms == 1);
                end
            end
            idle_inputs();
            if (ms == 1) begin
                load_valid = 1'b1; load_last = 1'b1; load_byte = 8'($urandom);
                tick();
                load_valid = 1'b0; load_last = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midload;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_byte = 8'($urandom); fetch_req = 1'b1; pc = 32'd0;
            tick();
        end
        idle_inputs();
        reset = 1'b0;
        model_reset();
        #1;
        tests++;
        if ({load_ready, load_done, load_err, fetch_valid, fetch_fault, busy} !== 6'b0 || instruction_code !== 32'h0) begin
            fails++;
            $display("FAIL midload_reset: got ready=%b done=%b err=%b fv=%b ff=%b busy=%b code=%h, want all 0",
                     load_ready, load_done, load_err, fetch_valid, fetch_fault, busy, instruction_code);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        fetch_req = 1'b1; pc = 32'd0;
        tick();
        fetch_req = 1'b0;
        tests++;
        if (fetch_valid !== 1'b1 || fetch_fault !== e_ff || (e_known && instruction_code !== e_code)) begin
            fails++;
            $display("FAIL post_reset_fetch: got fv=%b ff=%b code=%h, want 1 %b %h", fetch_valid, fetch_fault, instruction_code, e_ff, e_code);
        end
`ifndef IMEM_BOOT_PROG_EN
        tests++;
        if (fetch_fault !== 1'b1 || instruction_code !== NOP) begin
            fails++;
            $display("FAIL post_reset_fault: got ff=%b code=%h, want 1 %h", fetch_fault, instruction_code, NOP);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load();
        test_fault();
        test_overflow();
        test_collide();
        test_random();
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
